// File: rtl/dec8b10b_sync_ctrl.sv
// Word-sync controller for an 8B/10B decoder: acquires lock on K28.5 commas and forwards symbols only while synced.
// Latency: 1 cycle from an accepted symbol to out_valid and state views. Backpressure: none, since decoder results are consumed every cycle.
// Optional DEC8B10B_SYNC_STATS_EN adds saturating code/RD error counters.
module dec8b10b_sync_ctrl #(
    parameter int unsigned COMMA_CNT  = 3,
    parameter int unsigned ERR_LIMIT  = 4,
    parameter int unsigned GOOD_CNT   = 4,
    parameter logic [7:0]  COMMA_CODE = 8'hBC
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ctrl_en,
    output logic       dec_enable,
    output logic       dec_rd_init,
    input  logic       dec_valid,
    input  logic [7:0] dec_data,
    input  logic       dec_k_char,
    input  logic       dec_code_err,
    input  logic       dec_rd_err,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_k,
    output logic       sync_ok,
    output logic [2:0] err_level,
    output logic [7:0] lost_cnt
`ifdef DEC8B10B_SYNC_STATS_EN
    ,
    output logic [15:0] code_err_cnt,
    output logic [15:0] rd_err_cnt
`endif
);

    typedef enum logic [1:0] {LOS, COMMA_DET, SYNCED} state_t;

    state_t     state, state_nxt;
    logic [7:0] comma_cnt, comma_cnt_nxt;
    logic [7:0] good_run, good_run_nxt;
    logic [2:0] err_level_nxt;
    logic [7:0] lost_cnt_nxt;
    logic       fwd, to_los, rd_init_nxt;
    logic [3:0] err_inc;

    wire accept = dec_valid & dec_enable;
    wire bad    = dec_code_err | dec_rd_err;
    wire comma  = !bad & dec_k_char & (dec_data == COMMA_CODE);

    assign err_inc = {1'b0, err_level} + 4'd1;

    always_comb begin
        state_nxt     = state;
        comma_cnt_nxt = comma_cnt;
        good_run_nxt  = good_run;
        err_level_nxt = err_level;
        lost_cnt_nxt  = lost_cnt;
        fwd           = 1'b0;
        to_los        = 1'b0;
        if (!ctrl_en) begin
            state_nxt     = LOS;
            comma_cnt_nxt = 8'd0;
            good_run_nxt  = 8'd0;
            err_level_nxt = 3'd0;
        end else if (accept) begin
            case (state)
                LOS: begin
                    if (comma) begin
                        if (COMMA_CNT == 1) begin
                            state_nxt     = SYNCED;
                            err_level_nxt = 3'd0;
                            good_run_nxt  = 8'd0;
                        end else begin
                            state_nxt     = COMMA_DET;
                            comma_cnt_nxt = 8'd1;
                        end
                    end
                end
                COMMA_DET: begin
                    if (bad) begin
                        to_los = 1'b1;
                    end else if (comma) begin
                        if (comma_cnt + 8'd1 == 8'(COMMA_CNT)) begin
                            state_nxt     = SYNCED;
                            comma_cnt_nxt = 8'd0;
                            err_level_nxt = 3'd0;
                            good_run_nxt  = 8'd0;
                        end else begin
                            comma_cnt_nxt = comma_cnt + 8'd1;
                        end
                    end
                end
                SYNCED: begin
                    if (bad) begin
                        if (err_inc == 4'(ERR_LIMIT)) begin
                            to_los = 1'b1;
                            if (lost_cnt != 8'hFF) lost_cnt_nxt = lost_cnt + 8'd1;
                        end else begin
                            err_level_nxt = err_inc[2:0];
                            good_run_nxt  = 8'd0;
                            fwd           = 1'b1;
                        end
                    end else begin
                        fwd = 1'b1;
                        if (good_run + 8'd1 == 8'(GOOD_CNT)) begin
                            good_run_nxt = 8'd0;
                            if (err_level != 3'd0) err_level_nxt = err_level - 3'd1;
                        end else begin
                            good_run_nxt = good_run + 8'd1;
                        end
                    end
                end
                default: state_nxt = LOS;
            endcase
            if (to_los) begin
                state_nxt     = LOS;
                comma_cnt_nxt = 8'd0;
                good_run_nxt  = 8'd0;
                err_level_nxt = 3'd0;
            end
        end
        // Re-init RD on enable rising edge, and after losing lock while still enabled.
        rd_init_nxt = ctrl_en & (!dec_enable | to_los);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOS;
            comma_cnt   <= 8'd0;
            good_run    <= 8'd0;
            err_level   <= 3'd0;
            lost_cnt    <= 8'd0;
            dec_enable  <= 1'b0;
            dec_rd_init <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            out_k       <= 1'b0;
            sync_ok     <= 1'b0;
        end else begin
            state       <= state_nxt;
            comma_cnt   <= comma_cnt_nxt;
            good_run    <= good_run_nxt;
            err_level   <= err_level_nxt;
            lost_cnt    <= lost_cnt_nxt;
            dec_enable  <= ctrl_en;
            dec_rd_init <= rd_init_nxt;
            out_valid   <= fwd;
            sync_ok     <= (state_nxt == SYNCED);
            if (fwd) begin
                out_data <= dec_data;
                out_k    <= dec_k_char;
            end
        end
    end

`ifdef DEC8B10B_SYNC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_err_cnt <= 16'd0;
            rd_err_cnt   <= 16'd0;
        end else if (accept) begin
            if (dec_code_err && code_err_cnt != 16'hFFFF) code_err_cnt <= code_err_cnt + 16'd1;
            if (dec_rd_err && rd_err_cnt != 16'hFFFF) rd_err_cnt <= rd_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dec8b10b_sync_ctrl.md
Name: dec8b10b_sync_ctrl

Overview:
Link-synchronisation controller that sequences the 8B/10B decoder. It gates the decoder enable and pulses a running-disparity (RD) re-initialise. It consumes the per-symbol decoder outputs: data, k_char, code_err and rd_err. It acquires and tracks word sync on K28.5 commas and forwards decoded symbols downstream only while the link is synchronised.

Parameters:
COMMA_CNT, 3, consecutive-in-state K28.5 commas needed to declare sync (>=1)
ERR_LIMIT, 4, error level in SYNCED that forces loss of sync (>=1)
GOOD_CNT, 4, consecutive good symbols that decrement the error level by 1 (>=1)
COMMA_CODE, 8'hBC, decoded value that, with k_char=1, counts as a comma

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ctrl_en  in  1  controller enable from link management
dec_enable  out  1  drive to decoder enable
dec_rd_init  out  1  one-cycle pulse; decoder reloads RD to negative
dec_valid  in  1  decoder result valid this cycle
dec_data  in  8  decoded byte
dec_k_char  in  1  decoded symbol is a control character
dec_code_err  in  1  decoder code error
dec_rd_err  in  1  decoder RD error
out_valid  out  1  forwarded symbol valid
out_data  out  8  forwarded byte
out_k  out  1  forwarded control flag
sync_ok  out  1  high in SYNCED state
err_level  out  3  current error level
lost_cnt  out  8  saturating count of SYNCED->LOS transitions

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=LOS; every output 0; internal counters 0.
- dec_enable: registered copy of ctrl_en, one-cycle latency.
- Symbol acceptance: a symbol is accepted only when dec_valid=1 and dec_enable=1. All other cycles leave the FSM and counters unchanged.
- Symbol classes:
  - bad = dec_code_err | dec_rd_err
  - comma = !bad & dec_k_char & (dec_data==COMMA_CODE)
  - good = !bad
- dec_rd_init pulses high for exactly one cycle in each of these cases:
  - the first cycle dec_enable goes 0->1;
  - the cycle after any entry into LOS from COMMA_DET or SYNCED.
- The FSM has three states; the transitions below apply only on accepted symbols.
  - LOS:
    - comma -> COMMA_DET, comma_cnt=1.
    - If COMMA_CNT==1, comma goes directly to SYNCED instead.
    - Otherwise stay in LOS.
  - COMMA_DET:
    - bad -> LOS, comma_cnt=0.
    - comma -> comma_cnt+1; when it reaches COMMA_CNT -> SYNCED, err_level=0, good_run=0.
    - Good non-comma -> stay, comma_cnt unchanged.
  - SYNCED:
    - bad -> err_level+1, good_run=0. If the new err_level==ERR_LIMIT -> LOS and lost_cnt+1 (saturates at 255).
    - good -> good_run+1. When good_run reaches GOOD_CNT: good_run=0, and err_level-1 if it is nonzero.
- ctrl_en low:
  - The next cycle forces LOS with all counters cleared except lost_cnt.
  - lost_cnt is not incremented.
  - dec_rd_init does not pulse until re-enable.
- Output path:
  - out_valid=1 one cycle after each accepted symbol whose arrival state is SYNCED and which does not cause exit to LOS. The symbol that completes sync is not forwarded.
  - out_data and out_k are registered with the symbol and hold their value when out_valid=0.
  - Bad symbols in SYNCED that do not reach the limit are forwarded, with out_data=dec_data.
- sync_ok and err_level are registered state views and update the cycle after the causing symbol.
- Reset mid-operation clears everything immediately (asynchronous); no dec_rd_init pulse occurs until ctrl_en is seen high again.

Optional Feature:
DEC8B10B_SYNC_STATS_EN
- Defined: adds outputs code_err_cnt[15:0] and rd_err_cnt[15:0]. These count accepted symbols with dec_code_err and dec_rd_err respectively, in any state, saturating at 16'hFFFF. Both clear on reset only.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, ctrl_en=1, then 3 accepted K28.5 (k=1, data=BC) -> dec_rd_init pulses once after enable; sync_ok=1 the cycle after the 3rd comma; out_valid stays 0 for the commas up to and including the sync-completing one.
2. SYNCED, send D21.5 (data=B5, k=0) -> out_valid=1, out_data=B5, out_k=0, one cycle after dec_valid.
3. SYNCED, 4 symbols with code_err=1 -> err_level steps 1,2,3; the 4th gives sync_ok=0, lost_cnt=1, a dec_rd_init pulse the next cycle, and no out_valid for the 4th.
4. SYNCED, 1 rd_err followed by 4 good symbols -> err_level goes 1 then 0 after the 4th good symbol; sync_ok stays 1.
5. COMMA_DET with 2 commas, then one bad symbol -> LOS; 3 fresh commas are needed to resync.
6. SYNCED, drop ctrl_en -> dec_enable=0 and LOS next cycle; lost_cnt unchanged; dec_valid pulses while disabled are ignored.
